wall_follower: RTL and testbench



---
 rtl/wall_follower.sv | 209 ++++++++++++++++++++
 tb/tb_wall_follower.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wall_follower.sv
// Right-hand wall-following drive controller: sync/debounce, FSM, wheel regs.
// Optional WALL_FOLLOW_RAMP_EN limits per-cycle wheel change to RAMP_STEP.
module wall_follower #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_CYCLES     = 16,
  parameter int BACKUP_CYCLES   = 16,
  parameter int RAMP_STEP       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sensor_right,
  input  logic              sensor_left,
  input  logic              sensor_wall,
  input  logic [5:0]        speed,
  output logic signed [7:0] wheel_left,
  output logic signed [7:0] wheel_right
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FOLLOW = 3'd1;
  localparam logic [2:0] S_SEEK   = 3'd2;
  localparam logic [2:0] S_AVOID  = 3'd3;
  localparam logic [2:0] S_BACKUP = 3'd4;

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TURN_LD = 16'(TURN_CYCLES - 1);
  localparam logic [15:0] BACK_LD = 16'(BACKUP_CYCLES - 1);

`ifdef WALL_FOLLOW_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam logic signed [9:0] STEP10 = 10'(RAMP_STEP);
  localparam logic signed [7:0] STEP8  = 8'(RAMP_STEP);

  logic [2:0]  w_raw;
  logic [2:0]  r_s1;
  logic [2:0]  r_s2;
  logic [2:0]  r_deb;
  logic [7:0]  r_dcnt [3];
  logic [2:0]  r_state;
  logic [2:0]  w_nxt;
  logic [15:0] r_tmr;
  logic        w_ld;
  logic [15:0] w_ldv;
  logic        w_fr;
  logic        w_fl;
  logic        w_wall;
  logic signed [7:0] w_full;
  logic signed [7:0] w_half;
  logic signed [7:0] w_rev;
  logic signed [7:0] w_tl;
  logic signed [7:0] w_tr;
  logic signed [7:0] r_wl;
  logic signed [7:0] r_wr;

  assign w_raw  = {sensor_wall, sensor_left, sensor_right};
  assign w_fr   = r_deb[0];
  assign w_fl   = r_deb[1];
  assign w_wall = r_deb[2];

  // Debounced bit flips only after DEBOUNCE_CYCLES disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_deb <= '0;
      for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_deb[i]  <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    w_ld  = 1'b0;
    w_ldv = '0;
    if (!enable) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_BACKUP: begin
          if (r_tmr == '0) begin
            w_nxt = S_AVOID;
            w_ld  = 1'b1;
            w_ldv = TURN_LD;
          end
        end
        S_AVOID: begin
          if (r_tmr == '0) begin
            unique case (1'b1)
              (w_fl & w_fr): begin
                w_nxt = S_BACKUP;
                w_ld  = 1'b1;
                w_ldv = BACK_LD;
              end
              (w_fl ^ w_fr): w_nxt = S_AVOID;
              default: w_nxt = w_wall ? S_FOLLOW : S_SEEK;
            endcase
          end
        end
        default: begin
          unique case (1'b1)
            (w_fl & w_fr): begin
              w_nxt = S_BACKUP;
              w_ld  = 1'b1;
              w_ldv = BACK_LD;
            end
            (w_fl ^ w_fr): begin
              w_nxt = S_AVOID;
              w_ld  = 1'b1;
              w_ldv = TURN_LD;
            end
            default: w_nxt = w_wall ? S_FOLLOW : S_SEEK;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ld)
        r_tmr <= w_ldv;
      else if (r_tmr != '0)
        r_tmr <= r_tmr - 16'd1;
    end
  end

  assign w_full = {1'b0, speed, 1'b0};
  assign w_half = {2'b00, speed};
  assign w_rev  = -w_full;

  always_comb begin
    w_tl = '0;
    w_tr = '0;
    case (r_state)
      S_FOLLOW: begin
        w_tl = w_full;
        w_tr = w_full;
      end
      S_SEEK: begin
        w_tl = w_full;
        w_tr = w_half;
      end
      S_AVOID: begin
        w_tl = w_rev;
        w_tr = w_full;
      end
      S_BACKUP: begin
        w_tl = w_rev;
        w_tr = w_rev;
      end
      default: begin
        w_tl = '0;
        w_tr = '0;
      end
    endcase
  end

  function automatic logic signed [7:0] ramp(
    input logic signed [7:0] cur,
    input logic signed [7:0] tgt
  );
    logic signed [9:0] d;
    d = {{2{tgt[7]}}, tgt} - {{2{cur[7]}}, cur};
    if (d > STEP10)
      ramp = cur + STEP8;
    else if (d < -STEP10)
      ramp = cur - STEP8;
    else
      ramp = tgt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wl <= '0;
      r_wr <= '0;
    end else if (RAMP_EN) begin
      r_wl <= ramp(r_wl, w_tl);
      r_wr <= ramp(r_wr, w_tr);
    end else begin
      r_wl <= w_tl;
      r_wr <= w_tr;
    end
  end

  assign wheel_left  = r_wl;
  assign wheel_right = r_wr;

endmodule

// File: tb/tb_wall_follower.sv
// Scoreboard bench for wall_follower: expectations are queued with a due
// cycle when stimulus is driven and compared at the falling edge.
module tb_wall_follower;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              s_r = 1'b1;
  logic              s_l = 1'b1;
  logic              s_w = 1'b1;
  logic [5:0]        speed = 6'd63;
  logic signed [7:0] wl;
  logic signed [7:0] wr;

  typedef struct {
    int                due;
    string             tag;
    logic signed [7:0] l;
    logic signed [7:0] r;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  wall_follower dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sensor_right (s_r),
    .sensor_left  (s_l),
    .sensor_wall  (s_w),
    .speed        (speed),
    .wheel_left   (wl),
    .wheel_right  (wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d/%0d, expected %0d/%0d", tag,
               $signed(got[15:8]), $signed(got[7:0]),
               $signed(exp[15:8]), $signed(exp[7:0]));
    end
  endtask

  task automatic expect_at(int d, string tag, int l, int r);
    exp_t e;
    e.due = cyc + d;
    e.tag = $sformatf("%s+%0d", tag, d);
    e.l   = 8'(l);
    e.r   = 8'(r);
    q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due == cyc) begin
        check(q[i].tag, {wl, wr}, {q[i].l, q[i].r});
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #1 check("rst_async", {wl, wr}, 16'h0000);
    step(3);
    check("rst_held", {wl, wr}, 16'h0000);
    reset = 1'b1;
    for (int d = 1; d <= 12; d++) expect_at(d, "idle_en0", 0, 0);
    step(14);
    s_l = 1'b0;
    s_r = 1'b0;
    step(10);

`ifdef WALL_FOLLOW_RAMP_EN
    speed  = 6'd0;
    enable = 1'b1;
    step(4);
    speed = 6'd63;
    for (int k = 1; k <= 34; k++)
      expect_at(k, "ramp_up", (4 * k > 126) ? 126 : 4 * k,
                (4 * k > 126) ? 126 : 4 * k);
    step(36);
    speed = 6'd0;
    for (int k = 1; k <= 34; k++)
      expect_at(k, "ramp_dn", (126 - 4 * k < 0) ? 0 : 126 - 4 * k,
                (126 - 4 * k < 0) ? 0 : 126 - 4 * k);
    step(36);
    speed = 6'd20;
    step(12);
`else
    enable = 1'b1;
    expect_at(1, "en_pre", 0, 0);
    expect_at(2, "en_on", 126, 126);
    step(4);
    enable = 1'b0;
    expect_at(1, "dis_pre", 126, 126);
    expect_at(2, "dis", 0, 0);
    expect_at(5, "dis_hold", 0, 0);
    step(5);
    enable = 1'b1;
    expect_at(2, "reen", 126, 126);
    step(4);

    for (int s = 0; s <= 48; s += 8) begin
      speed = 6'(s);
      expect_at(1, "spd", 2 * s, 2 * s);
      step(3);
      s_w = 1'b0;
      expect_at(7, "seek_pre", 2 * s, 2 * s);
      expect_at(8, "seek", 2 * s, s);
      step(10);
      s_w = 1'b1;
      expect_at(8, "follow", 2 * s, 2 * s);
      step(10);
    end

    speed = 6'd32;
    expect_at(1, "g_spd", 64, 64);
    step(2);
    s_l = 1'b1;
    step(3);
    s_l = 1'b0;
    for (int d = 1; d <= 12; d++) expect_at(d, "glitch", 64, 64);
    step(14);

    s_l = 1'b1;
    expect_at(7, "turn_pre", 64, 64);
    expect_at(8, "turn_in", -64, 64);
    expect_at(23, "turn_min", -64, 64);
    expect_at(24, "turn_out", 64, 64);
    step(4);
    s_l = 1'b0;
    step(26);

    s_l = 1'b1;
    s_w = 1'b0;
    expect_at(8, "hold_in", -64, 64);
    expect_at(37, "hold_end", -64, 64);
    expect_at(38, "to_seek", 64, 32);
    step(30);
    s_l = 1'b0;
    step(10);
    s_w = 1'b1;
    expect_at(8, "refollow", 64, 64);
    step(10);

    speed = 6'd20;
    expect_at(1, "b_spd", 40, 40);
    step(3);
    s_l = 1'b1;
    s_r = 1'b1;
    expect_at(7, "back_pre", 40, 40);
    expect_at(8, "back_in", -40, -40);
    expect_at(23, "back_end", -40, -40);
    expect_at(24, "back_avoid", -40, 40);
    expect_at(39, "avoid_end", -40, 40);
    expect_at(40, "back_again", -40, -40);
    step(40);
    s_l = 1'b0;
    s_r = 1'b0;
    expect_at(31, "exit_pre", -40, 40);
    expect_at(32, "exit", 40, 40);
    step(34);
`endif

    check("sb_drain", 16'(q.size()), 16'h0000);
    check("pre_rst", {wl, wr}, {8'sd40, 8'sd40});
    #2 reset = 1'b0;
    #1 check("rst_mid", {wl, wr}, 16'h0000);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
